data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the core's data-memory interface. It accepts one load/store request at a time from the pipelined datapath over a valid/ready handshake and models a word-organised RAM with configurable wait states. It performs byte/halfword/word lane steering, applies sign or zero extension on loads, and returns an error flag for misaligned or out-of-range accesses. It sits between the datapath's memory stage and the on-chip data RAM. The core stalls its MEM stage until `rsp_valid`.

## Interface

Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words. Must be a power of two.
- `BASE_ADDRESS`, default 32'h00010000: byte address of word 0. Must be aligned to `DEPTH_WORDS*4`.
- `WAIT_STATES`, default 1: extra cycles per access, range 0..15.

Ports:
- `clock` in 1: the only clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_address` in 32: byte address.
- `req_write_data` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads zero-extend when 1, sign-extend when 0.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: core accepts the response.
- `rsp_read_data` out 32: load result. 0 for stores and errors.
- `rsp_error` out 1: request was illegal, misaligned or out of range.

## Operation

State machine states are IDLE, WAIT and RESPOND.

**IDLE**
- `req_ready`=1 and `rsp_valid`=0.
- On `req_valid`, latch write, address, data, size and unsigned.
- Next state is WAIT with counter = `WAIT_STATES`, or RESPOND directly if `WAIT_STATES`=0.

**WAIT**
- `req_ready`=0. The counter decrements each cycle.
- When the counter equals 1, the next state is RESPOND.

**RESPOND**
- `rsp_valid`=1 and `req_ready`=0.
- Stays in RESPOND until `rsp_ready`=1, then returns to IDLE.
- No request is accepted in the same cycle as the response handshake.

**Error detection** (computed on the latched request):
- `req_size`=11.
- Half access with addr[0]=1.
- Word access with addr[1:0]≠0.
- (addr − `BASE_ADDRESS`) ≥ `DEPTH_WORDS*4`, computed as unsigned 32-bit.
- On error: no array write, `rsp_read_data`=0, `rsp_error`=1.

**Array access** happens on the edge that enters RESPOND:
- Store: byte goes to lane addr[1:0]; half goes to lanes {addr[1],0} and {addr[1],1}; word goes to all lanes. Other lanes are unchanged.
- Load: read the addressed word, extract the lane, then extend to 32 bits per `req_unsigned`. Word loads ignore `req_unsigned`.
- `rsp_read_data` and `rsp_error` are registered at this edge. They hold stable through RESPOND regardless of request inputs.

**Memory contents**
- Undefined at power-up.
- Never cleared by `reset`.

## Timing

**Reset values** (cycle after `reset` sampled low): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_read_data`=0, `rsp_error`=0, counter 0.

**During reset**
- While `reset`=0, `req_valid` is ignored.
- Reset has priority over every transition.

**Latency**
- `rsp_valid` rises `WAIT_STATES`+1 cycles after the accepting edge.
- Throughput is one request per `WAIT_STATES`+2 cycles when `rsp_ready` is held high.

**Handshake rules**
- The responder holds `rsp_valid` and the response data stable until `rsp_ready`.
- The core must hold request signals only until acceptance; the responder does not sample them afterwards.

**Reset mid-operation**
- A request in WAIT is abandoned and its store is dropped.
- If `reset` is low on the edge that would commit a store, the write is suppressed.
- A response pending in RESPOND is discarded.

**Address boundaries**
- Address `BASE_ADDRESS`+`DEPTH_WORDS*4`−4 is legal.
- The next word, and any address below `BASE_ADDRESS`, sets `rsp_error`.
- Subtraction wrap for addresses below `BASE_ADDRESS` yields a large value, so they are flagged.

## Test plan

Default parameters (`WAIT_STATES`=1, `BASE_ADDRESS`=0x00010000) unless stated.

1. **Word store then load:** store word 0xDEADBEEF at 0x00010008, then load word 0x00010008. Each `rsp_valid` rises 2 cycles after acceptance; the load returns 0xDEADBEEF with `rsp_error`=0.
2. **Byte lanes and extension:** store word 0x11223344 at 0x0001000C, then store byte 0x80 at 0x0001000D.
   - Load word → 0x11228044.
   - Signed byte load of 0x0001000D → 0xFFFFFF80.
   - Unsigned byte load → 0x00000080.
   - Signed half load of 0x0001000C → 0xFFFF8044.
3. **Misaligned access:** half store at 0x00010001 → `rsp_error`=1, data 0. A word load of 0x00010000 afterwards is unchanged. A word load of 0x00010002 and `req_size`=11 also give `rsp_error`=1.
4. **Address range:** word load at 0x00010FFC (`DEPTH_WORDS`=1024) → no error. Word loads at 0x00011000 and 0x0000FFFC → `rsp_error`=1.
5. **Response backpressure:** hold `rsp_ready`=0 for 4 cycles during a load.
   - `rsp_valid` and data stay stable and `req_ready` stays 0.
   - A new `req_valid` is not accepted.
   - Handshake completes on the cycle `rsp_ready`=1, and `req_ready`=1 on the next cycle.
6. **Reset mid-store, and zero wait states:**
   - Assert `reset`=0 while a store of 0xCAFEF00D is in WAIT. No `rsp_valid` appears, and a subsequent load returns the prior value.
   - Repeat scenario 1 with `WAIT_STATES`=0: latency is 1 cycle.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between the datapath MEM stage and the data RAM responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_read_data;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_address, req_write_data, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_read_data, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_address, req_write_data, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_read_data, rsp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM responder with wait states, byte/half lane steering,
// load extension and misalignment/range error reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h0001_0000,
    parameter int unsigned WAIT_STATES  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned INDEX_WIDTH = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES  = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                 state_r;
    logic [3:0]             count_r;
    logic                   write_r;
    logic [31:0]            address_r;
    logic [31:0]            write_data_r;
    logic [1:0]             size_r;
    logic                   unsigned_r;
    logic                   req_ready_r;
    logic                   rsp_valid_r;
    logic [31:0]            rsp_read_data_r;
    logic                   rsp_error_r;
    logic [31:0]            mem_r [DEPTH_WORDS];

    logic                   op_write_s;
    logic [31:0]            op_address_s;
    logic [31:0]            op_write_data_s;
    logic [1:0]             op_size_s;
    logic                   op_unsigned_s;
    logic [INDEX_WIDTH-1:0] index_s;
    logic                   error_s;
    logic [31:0]            read_word_s;
    logic [31:0]            rsp_data_s;
    logic                   enter_respond_s;
    logic                   commit_s;

    function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] offset;
        logic        align_err;
        offset = addr - BASE_ADDRESS;
        case (size)
            2'b00:   align_err = 1'b0;
            2'b01:   align_err = addr[0];
            2'b10:   align_err = (addr[1:0] != 2'b00);
            default: align_err = 1'b1;
        endcase
        return align_err | (offset >= SPAN_BYTES);
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] data,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] w;
        w = old_word;
        case (size)
            2'b00: begin
                case (lane)
                    2'b00:   w[7:0]   = data[7:0];
                    2'b01:   w[15:8]  = data[7:0];
                    2'b10:   w[23:16] = data[7:0];
                    default: w[31:24] = data[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    w[31:16] = data[15:0];
                end else begin
                    w[15:0] = data[15:0];
                end
            end
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // With zero wait states the access happens on the accepting edge, so use the live request in IDLE.
    always_comb begin
        op_write_s      = write_r;
        op_address_s    = address_r;
        op_write_data_s = write_data_r;
        op_size_s       = size_r;
        op_unsigned_s   = unsigned_r;
        if (state_r == IDLE) begin
            op_write_s      = bus.req_write;
            op_address_s    = bus.req_address;
            op_write_data_s = bus.req_write_data;
            op_size_s       = bus.req_size;
            op_unsigned_s   = bus.req_unsigned;
        end else begin
            op_write_s      = write_r;
            op_address_s    = address_r;
            op_write_data_s = write_data_r;
            op_size_s       = size_r;
            op_unsigned_s   = unsigned_r;
        end
    end

    // BASE_ADDRESS is span-aligned, so the word index is just the low address bits.
    assign index_s     = op_address_s[INDEX_WIDTH+1:2];
    assign error_s     = access_error(op_size_s, op_address_s);
    assign read_word_s = mem_r[index_s];
    assign rsp_data_s  = (error_s || op_write_s) ? 32'h0000_0000
                       : load_extract(read_word_s, op_size_s, op_address_s[1:0], op_unsigned_s);

    // Flags the edge that moves the FSM into RESPOND.
    always_comb begin
        enter_respond_s = 1'b0;
        case (state_r)
            IDLE:    enter_respond_s = bus.req_valid && (WAIT_STATES == 32'd0);
            WAIT:    enter_respond_s = (count_r == 4'd1);
            default: enter_respond_s = 1'b0;
        endcase
    end

    assign commit_s = reset && enter_respond_s && op_write_s && !error_s;

    // RAM array; deliberately outside reset so contents survive it.
    always_ff @(posedge clock) begin
        if (commit_s) begin
            mem_r[index_s] <= store_merge(read_word_s, op_write_data_s, op_size_s, op_address_s[1:0]);
        end
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r         <= IDLE;
            count_r         <= 4'd0;
            write_r         <= 1'b0;
            address_r       <= 32'h0000_0000;
            write_data_r    <= 32'h0000_0000;
            size_r          <= 2'b00;
            unsigned_r      <= 1'b0;
            req_ready_r     <= 1'b1;
            rsp_valid_r     <= 1'b0;
            rsp_read_data_r <= 32'h0000_0000;
            rsp_error_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_r      <= bus.req_write;
                        address_r    <= bus.req_address;
                        write_data_r <= bus.req_write_data;
                        size_r       <= bus.req_size;
                        unsigned_r   <= bus.req_unsigned;
                        req_ready_r  <= 1'b0;
                        if (enter_respond_s) begin
                            state_r         <= RESPOND;
                            rsp_valid_r     <= 1'b1;
                            rsp_read_data_r <= rsp_data_s;
                            rsp_error_r     <= error_s;
                        end else begin
                            state_r <= WAIT;
                            count_r <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    count_r <= count_r - 4'd1;
                    if (enter_respond_s) begin
                        state_r         <= RESPOND;
                        rsp_valid_r     <= 1'b1;
                        rsp_read_data_r <= rsp_data_s;
                        rsp_error_r     <= error_s;
                    end
                end
                RESPOND: begin
                    if (bus.rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready_r;
    assign bus.rsp_valid     = rsp_valid_r;
    assign bus.rsp_read_data = rsp_read_data_r;
    assign bus.rsp_error     = rsp_error_r;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with one wait state, one with none,
// expected responses queued at issue time and compared when the response appears.
module tb_data_mem_responder;
    localparam int unsigned WS1 = 1;
    localparam int unsigned WS0 = 0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [32:0] exp_q [$];

    always #5 clock = ~clock;

    data_mem_responder_if bus1 ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.WAIT_STATES(WS1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    data_mem_responder #(.WAIT_STATES(WS0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit vld, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] size, input bit uns);
        bus1.req_valid = vld && !sel;
        bus0.req_valid = vld && sel;
        bus1.req_write = wr;          bus0.req_write = wr;
        bus1.req_address = addr;      bus0.req_address = addr;
        bus1.req_write_data = data;   bus0.req_write_data = data;
        bus1.req_size = size;         bus0.req_size = size;
        bus1.req_unsigned = uns;      bus0.req_unsigned = uns;
    endtask

    function automatic logic rv(input bit sel);
        return sel ? bus0.rsp_valid : bus1.rsp_valid;
    endfunction
    function automatic logic rr(input bit sel);
        return sel ? bus0.req_ready : bus1.req_ready;
    endfunction
    function automatic logic [31:0] rd(input bit sel);
        return sel ? bus0.rsp_read_data : bus1.rsp_read_data;
    endfunction
    function automatic logic re(input bit sel);
        return sel ? bus0.rsp_error : bus1.rsp_error;
    endfunction

    // sel=0 targets the one-wait-state instance, sel=1 the zero-wait-state one.
    task automatic transact(input string tag, input bit sel, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                            input logic [31:0] exp_data, input bit exp_err, input int hold);
        int          lat;
        int          exp_lat;
        bit          seen;
        bit          acc;
        logic [32:0] exp;
        exp_lat = (sel ? int'(WS0) : int'(WS1)) + 1;
        exp_q.push_back({exp_err, exp_data});
        bus0.rsp_ready = (hold == 0);
        bus1.rsp_ready = (hold == 0);
        @(negedge clock);
        drive(sel, 1'b1, wr, addr, wdata, size, uns);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = rr(sel);
            @(posedge clock);
            #1;
        end
        exp = exp_q.pop_front();
        check({tag, "/accept"}, 32'(acc), 32'd1);
        if (!acc) begin
            drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
            return;
        end
        // Scramble the request after acceptance; a pending duplicate request during backpressure.
        if (hold > 0) begin
            drive(sel, 1'b1, 1'b1, addr, 32'h5555_AAAA, 2'b10, 1'b0);
        end else begin
            drive(sel, 1'b0, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        lat  = 1;
        seen = rv(sel);
        while (!seen && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
            seen = rv(sel);
        end
        check({tag, "/rsp_valid"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
            check({tag, "/data"}, rd(sel), exp[31:0]);
            check({tag, "/error"}, 32'(re(sel)), 32'(exp[32]));
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clock);
            #1;
            check({tag, "/hold_valid"}, 32'(rv(sel)), 32'd1);
            check({tag, "/hold_data"}, rd(sel), exp[31:0]);
            check({tag, "/hold_ready"}, 32'(rr(sel)), 32'd0);
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        bus0.rsp_ready = 1'b1;
        bus1.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        check({tag, "/done_valid"}, 32'(rv(sel)), 32'd0);
        check({tag, "/done_ready"}, 32'(rr(sel)), 32'd1);
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b1, 32'h0001_0008, 32'h1234_5678, 2'b10, 1'b0);
        bus0.rsp_ready = 1'b1;
        bus1.rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset/req_ready1", 32'(bus1.req_ready), 32'd1);
        check("reset/rsp_valid1", 32'(bus1.rsp_valid), 32'd0);
        check("reset/data1", bus1.rsp_read_data, 32'h0);
        check("reset/error1", 32'(bus1.rsp_error), 32'd0);
        check("reset/req_ready0", 32'(bus0.req_ready), 32'd1);
        check("reset/rsp_valid0", 32'(bus0.rsp_valid), 32'd0);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("reset/idle_after", 32'(bus1.req_ready), 32'd1);

        transact("t1_store", 1'b0, 1'b1, 32'h0001_0008, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        transact("t1_load",  1'b0, 1'b0, 32'h0001_0008, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);

        transact("t2_sw",    1'b0, 1'b1, 32'h0001_000C, 32'h1122_3344, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        transact("t2_sb",    1'b0, 1'b1, 32'h0001_000D, 32'h0000_0080, 2'b00, 1'b0, 32'h0, 1'b0, 0);
        transact("t2_lw",    1'b0, 1'b0, 32'h0001_000C, 32'h0, 2'b10, 1'b0, 32'h1122_8044, 1'b0, 0);
        transact("t2_lb",    1'b0, 1'b0, 32'h0001_000D, 32'h0, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0, 0);
        transact("t2_lbu",   1'b0, 1'b0, 32'h0001_000D, 32'h0, 2'b00, 1'b1, 32'h0000_0080, 1'b0, 0);
        transact("t2_lh",    1'b0, 1'b0, 32'h0001_000C, 32'h0, 2'b01, 1'b0, 32'hFFFF_8044, 1'b0, 0);
        transact("t2_lhu",   1'b0, 1'b0, 32'h0001_000E, 32'h0, 2'b01, 1'b1, 32'h0000_1122, 1'b0, 0);

        transact("t3_init",  1'b0, 1'b1, 32'h0001_0000, 32'hA5A5_A5A5, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        transact("t3_sh_mis",1'b0, 1'b1, 32'h0001_0001, 32'h0000_FFFF, 2'b01, 1'b0, 32'h0, 1'b1, 0);
        transact("t3_lw_chk",1'b0, 1'b0, 32'h0001_0000, 32'h0, 2'b10, 1'b0, 32'hA5A5_A5A5, 1'b0, 0);
        transact("t3_lw_mis",1'b0, 1'b0, 32'h0001_0002, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        transact("t3_size11",1'b0, 1'b0, 32'h0001_0000, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 0);

        transact("t4_top_st",1'b0, 1'b1, 32'h0001_0FFC, 32'h0BAD_F00D, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        transact("t4_top_ld",1'b0, 1'b0, 32'h0001_0FFC, 32'h0, 2'b10, 1'b0, 32'h0BAD_F00D, 1'b0, 0);
        transact("t4_above", 1'b0, 1'b0, 32'h0001_1000, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        transact("t4_below", 1'b0, 1'b0, 32'h0000_FFFC, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);

        transact("t5_bp",    1'b0, 1'b0, 32'h0001_0008, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 4);
        transact("t5_after", 1'b0, 1'b0, 32'h0001_0008, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);

        transact("t6_prior", 1'b0, 1'b1, 32'h0001_0010, 32'h0102_0304, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b1, 32'h0001_0010, 32'hCAFE_F00D, 2'b10, 1'b0);
        @(posedge clock);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        check("t6/in_wait", 32'(bus1.req_ready), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("t6/rst_valid", 32'(bus1.rsp_valid), 32'd0);
        check("t6/rst_ready", 32'(bus1.req_ready), 32'd1);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            check("t6/no_rsp", 32'(bus1.rsp_valid), 32'd0);
        end
        transact("t6_reload", 1'b0, 1'b0, 32'h0001_0010, 32'h0, 2'b10, 1'b0, 32'h0102_0304, 1'b0, 0);

        transact("t6_ws0_st", 1'b1, 1'b1, 32'h0001_0008, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        transact("t6_ws0_ld", 1'b1, 1'b0, 32'h0001_0008, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);
        transact("t6_ws0_lb", 1'b1, 1'b0, 32'h0001_000B, 32'h0, 2'b00, 1'b0, 32'hFFFF_FFDE, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
